// File: rtl/ofdm_tx_frame_sched.sv
// ofdm_tx_frame_sched
// Frame-level scheduler for the OFDM transmit output. It shares one
// downstream sample port between the preamble generator and the IFFT path.
// A rising S_CYC_I starts a frame. The block then forwards PRE_LEN preamble
// samples, followed by whole SYM_LEN-sample data symbols. If the IFFT cycle
// drops mid-symbol, the remaining samples of that symbol are filled with
// zeros before the output cycle closes.
//
// Ports:
//   CLK_I, RST_I              clock, synchronous active-high reset
//   P_DAT_I/P_CYC_I/P_STB_I   preamble source, P_ACK_O accepts a sample
//   S_DAT_I/S_CYC_I/S_STB_I/S_WE_I  IFFT source, S_ACK_O accepts a sample
//   DAT_O/CYC_O/STB_O/WE_O    registered downstream port, ACK_I accepts
//   SYM_CNT_O                 complete symbols sent this frame (saturating)
//   PAD_ERR_O                 sticky flag: last symbol was zero-padded
//   BUSY_O                    scheduler is not idle
module ofdm_tx_frame_sched #(
    parameter int PRE_LEN = 320,
    parameter int SYM_LEN = 80,
    parameter int CNT_W   = 9
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [31:0] P_DAT_I,
    input  logic        P_CYC_I,
    input  logic        P_STB_I,
    output logic        P_ACK_O,
    input  logic [31:0] S_DAT_I,
    input  logic        S_CYC_I,
    input  logic        S_STB_I,
    input  logic        S_WE_I,
    output logic        S_ACK_O,
    output logic [31:0] DAT_O,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    input  logic        ACK_I,
    output logic [7:0]  SYM_CNT_O,
    output logic        PAD_ERR_O,
    output logic        BUSY_O
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAD   = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(SYM_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       sym_cnt_r;
    logic             pad_err_r;
    logic             s_cyc_d_r;
    logic [31:0]      dat_r;
    logic             stb_r;
    logic             cyc_r;

    logic             out_halt_s;
    logic             frame_start_s;
    logic             p_ack_s;
    logic             s_ack_s;
    logic             sel_vld_s;
    logic [31:0]      sel_dat_s;
    logic             busy_s;

    // Saturating increment for the symbol counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return 8'hFF;
        end else begin
            return v + 8'd1;
        end
    endfunction

    // A registered sample that is not yet accepted blocks every transfer.
    assign out_halt_s    = stb_r & ~ACK_I;
    assign frame_start_s = S_CYC_I & ~s_cyc_d_r;

    // State register.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_start_s) begin
                    state_nxt_s = ST_PRE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (p_ack_s && (cnt_r == PRE_LAST)) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_PRE;
                end
            end
            ST_DATA: begin
                // The counter seen here already includes an ack taken in the
                // last cycle S_CYC_I was high.
                if (!S_CYC_I) begin
                    if (cnt_r == CNT_ZERO) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_PAD;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PAD: begin
                if (!out_halt_s && (cnt_r == SYM_LAST)) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_PAD;
                end
            end
            ST_DRAIN: begin
                if (!stb_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Source acks and output-stage selection, decoded from the state.
    always_comb begin
        p_ack_s   = 1'b0;
        s_ack_s   = 1'b0;
        sel_vld_s = 1'b0;
        sel_dat_s = 32'd0;
        case (state_r)
            ST_PRE: begin
                p_ack_s   = P_CYC_I & P_STB_I & ~out_halt_s;
                sel_vld_s = p_ack_s;
                sel_dat_s = P_DAT_I;
            end
            ST_DATA: begin
                s_ack_s   = S_CYC_I & S_STB_I & S_WE_I & ~out_halt_s;
                sel_vld_s = s_ack_s;
                sel_dat_s = S_DAT_I;
            end
            ST_PAD: begin
                sel_vld_s = 1'b1;
                sel_dat_s = 32'd0;
            end
            default: begin
                p_ack_s   = 1'b0;
                s_ack_s   = 1'b0;
                sel_vld_s = 1'b0;
                sel_dat_s = 32'd0;
            end
        endcase
        busy_s = (state_r != ST_IDLE);
    end

    // Sample/symbol counters, frame status and output cycle.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            cnt_r     <= CNT_ZERO;
            sym_cnt_r <= 8'd0;
            pad_err_r <= 1'b0;
            cyc_r     <= 1'b0;
            s_cyc_d_r <= 1'b0;
        end else begin
            s_cyc_d_r <= S_CYC_I;
            case (state_r)
                ST_IDLE: begin
                    if (frame_start_s) begin
                        cnt_r     <= CNT_ZERO;
                        sym_cnt_r <= 8'd0;
                        pad_err_r <= 1'b0;
                        cyc_r     <= 1'b1;
                    end
                end
                ST_PRE: begin
                    if (p_ack_s) begin
                        if (cnt_r == PRE_LAST) begin
                            cnt_r <= CNT_ZERO;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                end
                ST_DATA: begin
                    if (s_ack_s) begin
                        if (cnt_r == SYM_LAST) begin
                            cnt_r     <= CNT_ZERO;
                            sym_cnt_r <= sat_inc8(sym_cnt_r);
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                end
                ST_PAD: begin
                    if (!out_halt_s) begin
                        if (cnt_r == SYM_LAST) begin
                            cnt_r     <= CNT_ZERO;
                            sym_cnt_r <= sat_inc8(sym_cnt_r);
                            pad_err_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!stb_r) begin
                        cyc_r <= 1'b0;
                    end
                end
                default: begin
                    cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

    // Output sample register, frozen while the downstream stalls.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            stb_r <= 1'b0;
            dat_r <= 32'd0;
        end else if (!out_halt_s) begin
            stb_r <= sel_vld_s;
            dat_r <= sel_dat_s;
        end
    end

    assign P_ACK_O   = p_ack_s;
    assign S_ACK_O   = s_ack_s;
    assign DAT_O     = dat_r;
    assign STB_O     = stb_r;
    assign WE_O      = stb_r;
    assign CYC_O     = cyc_r;
    assign SYM_CNT_O = sym_cnt_r;
    assign PAD_ERR_O = pad_err_r;
    assign BUSY_O    = busy_s;

endmodule

// File: doc/ofdm_tx_frame_sched.md
Name: ofdm_tx_frame_sched

Overview:
- Frame-level scheduler for the OFDM 802.11 transmit output.
- Sits after the IFFT modulator and the preamble generator and shares the single downstream sample port between them.
- On each packet it forwards exactly PRE_LEN preamble samples, then whole data symbols of SYM_LEN samples from the IFFT path.
- Pads a truncated last symbol with zeros, then closes the output cycle.

Parameters:
PRE_LEN, 320, preamble samples per frame (short + long training)
SYM_LEN, 80, samples per data symbol (64 IFFT + 16 CP)
CNT_W, 9, width of sample counter (must hold max(PRE_LEN,SYM_LEN)-1)

Ports:
CLK_I  in  1  clock
RST_I  in  1  reset; synchronous, active-high
P_DAT_I  in  32  preamble sample {I[31:16],Q[15:0]}
P_CYC_I  in  1  preamble source cycle
P_STB_I  in  1  preamble sample valid
P_ACK_O  out  1  preamble sample accepted
S_DAT_I  in  32  IFFT symbol sample
S_CYC_I  in  1  IFFT output cycle; rising edge starts a frame, falling edge ends data
S_STB_I  in  1  symbol sample valid
S_WE_I  in  1  symbol write enable
S_ACK_O  out  1  symbol sample accepted
DAT_O  out  32  output sample
CYC_O  out  1  output frame cycle
STB_O  out  1  output sample valid
WE_O  out  1  equals STB_O
ACK_I  in  1  downstream accept
SYM_CNT_O  out  8  complete data symbols sent in current frame, saturates at 255
PAD_ERR_O  out  1  sticky: last symbol was zero-padded
BUSY_O  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; DAT_O=0, CYC_O=0, STB_O=0, SYM_CNT_O=0, PAD_ERR_O=0; counters 0; s_cyc_d=0.
- out_halt = STB_O & ~ACK_I. While out_halt, DAT_O/STB_O hold and no input is acked.
- Output register: when ~out_halt, STB_O <= selected-valid and DAT_O <= selected-data (zero in PAD). One cycle from input ack to STB_O.
- IDLE:
  - S_CYC_I & ~s_cyc_d -> PRE.
  - CYC_O<=1; sample counter, SYM_CNT_O and PAD_ERR_O cleared.
  - P_ACK_O=S_ACK_O=0.
- PRE:
  - P_ACK_O = P_CYC_I & P_STB_I & ~out_halt; S_ACK_O=0.
  - Each ack increments the counter; the PRE_LEN-th ack clears it -> DATA.
  - Source stall gives bubbles (STB_O=0), no count.
- DATA:
  - S_ACK_O = S_CYC_I & S_STB_I & S_WE_I & ~out_halt; P_ACK_O=0.
  - Counter wraps at SYM_LEN-1; each wrap increments SYM_CNT_O (saturating).
  - If ~S_CYC_I and counter==0 -> DRAIN.
  - If ~S_CYC_I and counter!=0 -> PAD.
  - An ack and the S_CYC_I fall in the same cycle: the ack counts first, then the condition is evaluated on the updated counter next cycle.
- PAD:
  - Each cycle with ~out_halt emits 0 with STB_O=1 and increments the counter.
  - On wrap: SYM_CNT_O++, PAD_ERR_O<=1 -> DRAIN.
  - No input acks.
- DRAIN:
  - No acks; the loaded STB_O becomes 0 once accepted.
  - When STB_O==0 (last sample taken): CYC_O<=0 -> IDLE.
- A rising S_CYC_I outside IDLE is ignored. A new frame can start the cycle after returning to IDLE.
- Reset mid-operation: everything returns to reset values in the next cycle, with no partial flush.
- Status:
  - SYM_CNT_O and PAD_ERR_O hold after the frame until the next frame start.
  - BUSY_O is combinational from state.

Test Plan:
- 2-symbol frame, ACK_I=1, sources always valid -> STB_O high 480 contiguous cycles: 320 preamble then 160 IFFT samples in order. SYM_CNT_O=2, PAD_ERR_O=0, CYC_O low 1 cycle after last sample.
- Same frame, ACK_I pseudo-random 50% -> DAT_O stable whenever STB_O&~ACK_I; 480 samples received with no loss or duplication; no P_ACK_O/S_ACK_O during out_halt.
- S_CYC_I falls after 45 samples of symbol 3 -> 35 zero samples appended, SYM_CNT_O=3, PAD_ERR_O=1, total output 320+240.
- Preamble stalls 10 cycles at sample 100, S_STB_I high throughout -> 10 bubble cycles; S_ACK_O=0 until all 320 preamble samples are acked; then data follows.
- RST_I pulsed during DATA symbol 1 sample 20 -> next cycle CYC_O=STB_O=0, BUSY_O=0. A new S_CYC_I rise restarts with the full 320-sample preamble.
- S_CYC_I rises again while in DATA -> ignored, no counter clear. Frame ends normally after S_CYC_I falls on a symbol boundary, with PAD_ERR_O=0.
